// File: rtl/fp_square_seq.sv
// Sequential binary32 squarer: radix-2 shift-add mantissa product, RNE, flush-to-zero.
// Define FPSQ_STATUS_EN to add the flags[3:0] = {invalid, overflow, underflow, inexact} port.
module fp_square_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef FPSQ_STATUS_EN
    output logic [3:0]      flags,
`endif
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_exp;
    logic [23:0] r_m;
    logic [47:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_special;
    logic [31:0] w_spec_res;
    logic [47:0] w_addend;

    logic signed [9:0] w_e_base;
    logic signed [9:0] w_e_norm;
    logic        w_hi;
    logic [22:0] w_mant;
    logic        w_g;
    logic        w_s;
    logic        w_rnd;
    logic [23:0] w_msum;
    logic        w_ovf;
    logic        w_unf;
    logic [31:0] w_norm_res;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

    assign w_special  = (A[30:23] == 8'd0) || (A[30:23] == 8'hFF);
    assign w_spec_res = (A[30:23] == 8'd0) ? 32'h0000_0000 :
                        (A[22:0] != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;

    assign w_addend = r_m[r_cnt] ? ({24'd0, r_m} << r_cnt) : 48'd0;

    // Product lies in [1,4); bit 47 selects the extra exponent step.
    assign w_e_base = $signed({1'b0, r_exp, 1'b0}) - 10'sd127;
    assign w_hi     = r_acc[47];
    assign w_mant   = w_hi ? r_acc[46:24] : r_acc[45:23];
    assign w_g      = w_hi ? r_acc[23] : r_acc[22];
    assign w_s      = w_hi ? (|r_acc[22:0]) : (|r_acc[21:0]);
    assign w_rnd    = w_g & (w_s | w_mant[0]);
    assign w_msum   = {1'b0, w_mant} + {23'd0, w_rnd};
    assign w_e_norm = w_e_base + $signed({9'd0, w_hi}) + $signed({9'd0, w_msum[23]});
    assign w_ovf    = (w_e_norm >= 10'sd255);
    assign w_unf    = (w_e_norm <= 10'sd0);

    always_comb begin
        w_norm_res = {1'b0, w_e_norm[7:0], w_msum[22:0]};
        if (w_ovf) begin
            w_norm_res = 32'h7F80_0000;
        end else if (w_unf) begin
            w_norm_res = 32'h0000_0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_next = w_special ? DONE : MUL;
            MUL:  if (r_cnt == 5'd23) w_next = NORM;
            NORM: w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp    <= 8'd0;
            r_m      <= 24'd0;
            r_acc    <= 48'd0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_exp <= A[30:23];
                        r_m   <= {1'b1, A[22:0]};
                        r_acc <= 48'd0;
                        r_cnt <= 5'd0;
                        if (w_special) r_result <= w_spec_res;
                    end
                end
                MUL: begin
                    r_acc <= r_acc + w_addend;
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM:    r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

`ifdef FPSQ_STATUS_EN
    logic [3:0] r_flags;
    logic       w_nan_in;

    assign w_nan_in = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    assign flags    = r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (r_state == IDLE && in_valid && w_special) begin
            r_flags <= {w_nan_in, 3'b000};
        end else if (r_state == NORM) begin
            r_flags <= {1'b0, w_ovf, w_unf & ~w_ovf, w_g | w_s | w_ovf | w_unf};
        end
    end
`endif

endmodule

// File: tb/tb_fp_square_seq.sv
// Directed bench for fp_square_seq with an integer-arithmetic reference model.
module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
`ifdef FPSQ_STATUS_EN
    logic [3:0]  flags;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fp_square_seq #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FPSQ_STATUS_EN
        .flags(flags),
`endif
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {flags, result} from the arithmetic definition of a rounded square.
    function automatic logic [35:0] model(input logic [31:0] a);
        int e;
        int sh;
        longint unsigned m, p, q, rem, half;
        logic inex;
        if (a[30:23] == 8'd0) return {4'b0000, 32'h0000_0000};
        if (a[30:23] == 8'hFF)
            return (a[22:0] != 23'd0) ? {4'b1000, 32'h7FC0_0000}
                                      : {4'b0000, 32'h7F80_0000};
        m = {40'd1, a[22:0]};
        p = m * m;
        e = 2 * int'(a[30:23]) - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inex = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
        if (e >= 255) return {4'b0101, 32'h7F80_0000};
        if (e <= 0) return {4'b0011, 32'h0000_0000};
        return {3'b000, inex, 1'b0, e[7:0], q[22:0]};
    endfunction

    logic [35:0] q_exp[$];
    int          q_t[$];
    int          q_lat[$];
    bit          seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q_exp.delete();
            q_t.delete();
            q_lat.delete();
            seen = 0;
        end else begin
            if (in_valid && in_ready) begin
                q_exp.push_back(model(A));
                q_t.push_back(cyc);
                q_lat.push_back((A[30:23] == 8'd0 || A[30:23] == 8'hFF) ? 1 : 26);
            end
            if (out_valid) begin
                total++;
                if (q_exp.size() == 0) begin
                    bad++;
                    $display("FAIL stale_output: result=%h with no op pending", result);
                end else begin
                    if (result !== q_exp[0][31:0]) begin
                        bad++;
                        $display("FAIL model_result: got %h want %h", result, q_exp[0][31:0]);
                    end
                    total++;
                    if (in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL ready_while_done: got %b want 0", in_ready);
                    end
`ifdef FPSQ_STATUS_EN
                    total++;
                    if (flags !== q_exp[0][35:32]) begin
                        bad++;
                        $display("FAIL model_flags: got %b want %b", flags, q_exp[0][35:32]);
                    end
`endif
                    if (!seen) begin
                        seen = 1;
                        total++;
                        if (cyc - q_t[0] != q_lat[0]) begin
                            bad++;
                            $display("FAIL latency: got %0d want %0d", cyc - q_t[0], q_lat[0]);
                        end
                    end
                    if (out_ready) begin
                        void'(q_exp.pop_front());
                        void'(q_t.pop_front());
                        void'(q_lat.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] want,
                      input int stall, input bit noise);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        A = a;
        @(posedge clk); #2;
        A = 32'hDEAD_BEEF;
        in_valid = noise;
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #2;
            n++;
            if (n == 10) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        check("literal_result", result, want);
        repeat (stall) begin
            @(posedge clk); #2;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", result, want);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        op(32'h4040_0000, 32'h4110_0000, 0, 1'b1);
        op(32'hBFC0_0000, 32'h4010_0000, 0, 1'b0);
        op(32'h3F80_0001, 32'h3F80_0002, 0, 1'b0);
`ifdef FPSQ_STATUS_EN
        check("inexact_flag", {28'd0, flags}, 32'h1);
`endif
        op(32'h7F00_0000, 32'h7F80_0000, 0, 1'b0);
        op(32'h1F80_0000, 32'h0000_0000, 0, 1'b0);
        op(32'h0000_0001, 32'h0000_0000, 0, 1'b0);
        op(32'h7FC0_0001, 32'h7FC0_0000, 0, 1'b0);
        op(32'hFF80_0000, 32'h7F80_0000, 0, 1'b0);
        op(32'h4040_0000, 32'h4110_0000, 5, 1'b0);

        in_valid = 1'b1;
        A = 32'h4040_0000;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_valid_rel", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #2;
        op(32'h4000_0000, 32'h4080_0000, 0, 1'b0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
